mlp_adc_frame_sequencer: RTL and testbench

// Sequences one shared low-precision ADC across the sensor channels of a printed
// MLP classifier. Per start, converts each enabled channel in order, buffers the

---
 rtl/mlp_adc_frame_sequencer_if.sv | 29 ++
 rtl/mlp_adc_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mlp_adc_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_adc_frame_sequencer_if.sv
// ADC request/ack bus, MLP feature/class bus and class valid/ready handshake
// between the frame sequencer (master) and its environment (slave).
interface mlp_adc_frame_sequencer_if #(
    parameter int N_CH     = 7,
    parameter int ADC_BITS = 4,
    parameter int OUT_BITS = 2
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     adc_req;
    logic [CH_W-1:0]          adc_ch;
    logic                     adc_ack;
    logic [ADC_BITS-1:0]      adc_data;
    logic [N_CH*ADC_BITS-1:0] mlp_inp;
    logic [OUT_BITS-1:0]      mlp_out;
    logic [OUT_BITS-1:0]      class_out;
    logic                     class_valid;
    logic                     class_ready;

    modport master (
        output adc_req, adc_ch, mlp_inp, class_out, class_valid,
        input  adc_ack, adc_data, mlp_out, class_ready
    );

    modport slave (
        input  adc_req, adc_ch, mlp_inp, class_out, class_valid,
        output adc_ack, adc_data, mlp_out, class_ready
    );
endinterface

// File: rtl/mlp_adc_frame_sequencer.sv
// Shares one ADC across the enabled MLP sensor channels, loads the feature
// vector atomically, waits for the MLP to settle and hands out its class.
module mlp_adc_frame_sequencer #(
    parameter int              N_CH        = 7,
    parameter int              ADC_BITS    = 4,
    parameter logic [N_CH-1:0] CH_MASK     = {N_CH{1'b1}},
    parameter int              MLP_LAT     = 1,
    parameter int              ADC_TIMEOUT = 15,
    parameter int              OUT_BITS    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic adc_err,
    mlp_adc_frame_sequencer_if.master bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int W    = N_CH * ADC_BITS;
    localparam int TW   = $clog2(ADC_TIMEOUT + 1);
    localparam int LW   = (MLP_LAT > 1) ? $clog2(MLP_LAT) : 1;

    localparam logic [TW-1:0] TMO_END = TW'(ADC_TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_END = LW'(MLP_LAT - 1);

    function automatic logic [W-1:0] slot_mask();
        logic [W-1:0] m;
        m = '0;
        for (int k = 0; k < N_CH; k++)
            m[k*ADC_BITS +: ADC_BITS] = {ADC_BITS{CH_MASK[k]}};
        return m;
    endfunction

    function automatic logic [CH_W-1:0] first_ch();
        logic [CH_W-1:0] f;
        f = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (CH_MASK[k]) f = CH_W'(k);
        return f;
    endfunction

    localparam logic [W-1:0]    SLOT_MASK = slot_mask();
    localparam logic [CH_W-1:0] FIRST_CH  = first_ch();

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_GAP, S_SETTLE, S_OUT
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic [CH_W-1:0]     ch_q;
    logic [W-1:0]        buf_q;
    logic [W-1:0]        inp_q;
    logic [TW-1:0]       tmo_q;
    logic [LW-1:0]       lat_q;
    logic [OUT_BITS-1:0] cls_q;
    logic                vld_q;
    logic                err_q;

    logic [CH_W-1:0]     nxt_ch;
    logic                nxt_vld;
    logic                timeout;
    logic                capture;
    logic [ADC_BITS-1:0] sample;
    logic [W-1:0]        buf_d;

    always_comb begin
        nxt_ch  = '0;
        nxt_vld = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (CH_MASK[k] && (k > int'(ch_q))) begin
                nxt_ch  = CH_W'(k);
                nxt_vld = 1'b1;
            end
        end
        timeout = !bus.adc_ack && (tmo_q == TMO_END);
        capture = bus.adc_ack || timeout;
        // A timed-out conversion stores zero in its slot
        sample  = bus.adc_ack ? bus.adc_data : '0;
        buf_d   = buf_q;
        buf_d[int'(ch_q)*ADC_BITS +: ADC_BITS] = sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            ch_q    <= '0;
            buf_q   <= '0;
            inp_q   <= '0;
            tmo_q   <= '0;
            lat_q   <= '0;
            cls_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (CH_MASK == '0) begin
                            inp_q   <= '0;
                            lat_q   <= '0;
                            state_q <= S_SETTLE;
                        end else begin
                            ch_q    <= FIRST_CH;
                            tmo_q   <= '0;
                            req_q   <= 1'b1;
                            state_q <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    if (capture) begin
                        buf_q <= buf_d;
                        req_q <= 1'b0;
                        if (timeout) err_q <= 1'b1;
                        if (nxt_vld) begin
                            ch_q    <= nxt_ch;
                            state_q <= S_GAP;
                        end else begin
                            inp_q   <= buf_d & SLOT_MASK;
                            lat_q   <= '0;
                            state_q <= S_SETTLE;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_GAP: begin
                    req_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= S_CONV;
                end
                S_SETTLE: begin
                    if (lat_q == LAT_END) begin
                        cls_q   <= bus.mlp_out;
                        vld_q   <= 1'b1;
                        state_q <= S_OUT;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.class_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign adc_err         = err_q;
    assign bus.adc_req     = req_q;
    assign bus.adc_ch      = ch_q;
    assign bus.mlp_inp     = inp_q;
    assign bus.class_out   = cls_q;
    assign bus.class_valid = vld_q;
endmodule

// File: tb/tb_mlp_adc_frame_sequencer.sv
// Directed bench for mlp_adc_frame_sequencer: full mask, partial mask,
// timeout, output back-pressure, mid-frame reset and random ack delay.
module tb_mlp_adc_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, busy_b, err_a, err_b;
    logic ready_a = 1'b1;
    int   mode = 0;
    logic rack = 1'b0;
    logic [3:0] rdata = 4'd0;
    int   dcnt = 0;
    int   tgt = 0;
    int   n_chk = 0;
    int   n_err = 0;

    logic       mon_en = 1'b0;
    logic       prev_req = 1'b0;
    logic [2:0] prev_ch = 3'd0;
    int         lowrun = 0;
    logic       seen = 1'b0;
    logic [3:0] exp_s [7];

    always #5 clk = ~clk;

    mlp_adc_frame_sequencer_if #(.N_CH(7), .ADC_BITS(4), .OUT_BITS(2)) ifa ();
    mlp_adc_frame_sequencer_if #(.N_CH(7), .ADC_BITS(4), .OUT_BITS(2)) ifb ();

    mlp_adc_frame_sequencer #(
        .N_CH(7), .ADC_BITS(4), .CH_MASK(7'h7F),
        .MLP_LAT(1), .ADC_TIMEOUT(15), .OUT_BITS(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .adc_err(err_a), .bus(ifa.master)
    );

    mlp_adc_frame_sequencer #(
        .N_CH(7), .ADC_BITS(4), .CH_MASK(7'h5F),
        .MLP_LAT(1), .ADC_TIMEOUT(15), .OUT_BITS(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .adc_err(err_b), .bus(ifb.master)
    );

    function automatic logic [1:0] mlp_f(input logic [27:0] v);
        return v[5:4] ^ v[13:12];
    endfunction

    assign ifa.adc_ack = (mode == 0) ? 1'b1 :
                         (mode == 1) ? (ifa.adc_ch != 3'd2) : rack;
    assign ifa.adc_data = (mode == 2) ? rdata : ({1'b0, ifa.adc_ch} + 4'd1);
    assign ifa.mlp_out = mlp_f(ifa.mlp_inp);
    assign ifa.class_ready = ready_a;

    assign ifb.adc_ack = 1'b1;
    assign ifb.adc_data = {1'b0, ifb.adc_ch} + 4'd1;
    assign ifb.mlp_out = mlp_f(ifb.mlp_inp);
    assign ifb.class_ready = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Random-latency ADC model
    always @(posedge clk) begin
        #1;
        rdata = 4'($urandom);
        if (mode == 2) begin
            if (!ifa.adc_req) begin
                rack = 1'b0;
                dcnt = 0;
                tgt  = $urandom_range(0, 5);
            end else if (dcnt == tgt) begin
                rack = 1'b1;
            end else begin
                rack = 1'b0;
                dcnt++;
            end
        end else begin
            rack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (ifa.adc_req && ifa.adc_ack) exp_s[ifa.adc_ch] = ifa.adc_data;
            if (ifa.adc_req && prev_req) chk("ch_stable", 32'(ifa.adc_ch), 32'(prev_ch));
            if (ifa.adc_req && !prev_req && seen) chk("gap_len", lowrun, 1);
            if (ifa.adc_req) begin
                seen   = 1'b1;
                lowrun = 0;
            end else begin
                lowrun++;
            end
            if (!busy_a) seen = 1'b0;
            prev_req = ifa.adc_req;
            prev_ch  = ifa.adc_ch;
        end
    end

    // Full-mask frame with ack tied high; returns in cycle 15 (class_valid high)
    task automatic full_frame(input logic [27:0] prev_inp);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 1) chk("err_clr", err_a, 0);
            if (c <= 13 && (c % 2) == 1) begin
                chk("req_on", ifa.adc_req, 1);
                chk("ch_seq", 32'(ifa.adc_ch), (c - 1) / 2);
            end
            if (c == 12) chk("gap_req", ifa.adc_req, 0);
            if (c == 13) chk("inp_hold", ifa.mlp_inp, prev_inp);
            if (c == 14) begin
                chk("inp_load", ifa.mlp_inp, 28'h7654321);
                chk("vld_early", ifa.class_valid, 0);
            end
            if (c == 15) begin
                chk("vld_c15", ifa.class_valid, 1);
                chk("cls_c15", ifa.class_out, 2'd2);
                chk("busy_out", busy_a, 1);
            end
            if (c < 15) step();
        end
    endtask

    initial begin
        int c;
        int cnt2;
        int n;
        logic saw5;
        logic [27:0] ev;

        for (int k = 0; k < 7; k++) exp_s[k] = 4'd0;
        step();
        step();
        chk("rst_busy", busy_a, 0);
        chk("rst_req", ifa.adc_req, 0);
        chk("rst_vld", ifa.class_valid, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ch", 32'(ifa.adc_ch), 0);
        chk("rst_cls", ifa.class_out, 0);
        chk("rst_inp", ifa.mlp_inp, 0);
        rst_n = 1'b1;
        step();

        mode = 0;
        ready_a = 1'b1;
        full_frame(28'h0);
        step();
        chk("hs_vld", ifa.class_valid, 0);
        chk("hs_busy", busy_a, 0);

        mode = 1;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        c = 1;
        cnt2 = 0;
        while (!ifa.class_valid && c < 60) begin
            if (ifa.adc_req && ifa.adc_ch == 3'd2) cnt2++;
            step();
            c++;
        end
        chk("tmo_vcyc", c, 29);
        chk("tmo_req2", cnt2, 15);
        chk("tmo_inp", ifa.mlp_inp, 28'h7654021);
        chk("tmo_err", err_a, 1);
        chk("tmo_cls", ifa.class_out, 2'd2);
        step();
        chk("err_stky", err_a, 1);
        chk("tmo_idle", busy_a, 0);

        mode = 0;
        ready_a = 1'b0;
        full_frame(28'h7654021);
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 3);
            chk("bp_vld", ifa.class_valid, 1);
            chk("bp_cls", ifa.class_out, 2'd2);
            chk("bp_busy", busy_a, 1);
            step();
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        step();
        chk("bp_hsv", ifa.class_valid, 0);
        chk("bp_hsb", busy_a, 0);
        step();
        chk("noqueue", busy_a, 0);
        chk("noq_req", ifa.adc_req, 0);

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_ch3", 32'(ifa.adc_ch), 3);
        chk("mid_req", ifa.adc_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_req", ifa.adc_req, 0);
        chk("ar_ch", 32'(ifa.adc_ch), 0);
        chk("ar_busy", busy_a, 0);
        chk("ar_inp", ifa.mlp_inp, 0);
        chk("ar_vld", ifa.class_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        full_frame(28'h0);
        step();
        chk("rr_idle", busy_a, 0);

        mode = 2;
        mon_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            step();
            start_a = 1'b1;
            step();
            start_a = 1'b0;
            n = 0;
            while (!ifa.class_valid && n < 200) begin
                step();
                n++;
            end
            chk("rnd_done", ifa.class_valid, 1);
            ev = '0;
            for (int k = 0; k < 7; k++) ev[k*4 +: 4] = exp_s[k];
            chk("rnd_inp", ifa.mlp_inp, ev);
            chk("rnd_cls", ifa.class_out, mlp_f(ev));
            chk("rnd_err", err_a, 0);
            step();
        end
        mon_en = 1'b0;
        mode = 0;

        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        saw5 = 1'b0;
        for (int cb = 1; cb <= 13; cb++) begin
            if (ifb.adc_req && ifb.adc_ch == 3'd5) saw5 = 1'b1;
            if (cb == 1) chk("m_ch0", 32'(ifb.adc_ch), 0);
            if (cb == 11) chk("m_ch6", 32'(ifb.adc_ch), 6);
            if (cb == 12) chk("m_vld12", ifb.class_valid, 0);
            if (cb == 13) begin
                chk("m_vld13", ifb.class_valid, 1);
                chk("m_inp", ifb.mlp_inp, 28'h7054321);
                chk("m_cls", ifb.class_out, 2'd2);
            end
            if (cb < 13) step();
        end
        chk("m_no_ch5", saw5, 0);
        step();
        chk("m_idle", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
